// File: rtl/bram_port_arbiter_if.sv
// Requester-side and BRAM-side signals of the shared BRAM port arbiter.
// slave = arbiter view; master = requesters plus BRAM output (test/system side).
interface bram_port_arbiter_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 10
);
    logic              r0_req;
    logic              r0_we;
    logic              r0_lock;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_wdata;
    logic              r0_gnt;
    logic              r0_rvalid;
    logic [DATA_W-1:0] r0_rdata;

    logic              r1_req;
    logic              r1_we;
    logic              r1_lock;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_wdata;
    logic              r1_gnt;
    logic              r1_rvalid;
    logic [DATA_W-1:0] r1_rdata;

    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_data;
    logic              bram_we;
    logic [DATA_W-1:0] bram_q;
    logic              locked;

    modport slave (
        input  r0_req, r0_we, r0_lock, r0_addr, r0_wdata,
        input  r1_req, r1_we, r1_lock, r1_addr, r1_wdata,
        input  bram_q,
        output r0_gnt, r0_rvalid, r0_rdata,
        output r1_gnt, r1_rvalid, r1_rdata,
        output bram_addr, bram_data, bram_we, locked
    );

    modport master (
        output r0_req, r0_we, r0_lock, r0_addr, r0_wdata,
        output r1_req, r1_we, r1_lock, r1_addr, r1_wdata,
        output bram_q,
        input  r0_gnt, r0_rvalid, r0_rdata,
        input  r1_gnt, r1_rvalid, r1_rdata,
        input  bram_addr, bram_data, bram_we, locked
    );
endinterface

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter with lock/timeout sharing one BRAM port between two requesters.
// Define ARB_FIXED_PRIORITY_EN to make r0 win every IDLE tie instead of round-robin.
module bram_port_arbiter #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned LOCK_MAX = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    bram_port_arbiter_if.slave   bus
);
    localparam int unsigned      CNT_W    = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_last;
    logic              w_last_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;

    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_any_gnt;
    logic              w_tie_r0;
    logic              w_timeout;
    logic              w_win_lock;
    logic              w_win_we;
    logic [ADDR_W-1:0] w_win_addr;
    logic [DATA_W-1:0] w_win_data;

    logic [ADDR_W-1:0] r_bram_addr;
    logic [DATA_W-1:0] r_bram_data;
    logic              r_bram_we;

    // Read-return pipeline: stage 1 = access on BRAM, stage 2 = data on bram_q
    logic              r_v1;
    logic              r_id1;
    logic              r_v2;
    logic              r_id2;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    // r_last = 1 means r1 was granted last, so r0 wins the next tie
`ifdef ARB_FIXED_PRIORITY_EN
    assign w_tie_r0 = 1'b1;
`else
    assign w_tie_r0 = r_last;
`endif

    // Next-state, grant and winner selection
    always_comb begin
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_cnt_nxt   = '0;
        w_timeout   = (r_state != IDLE) && (r_cnt == CNT_LAST);

        case (r_state)
            IDLE: begin
                if (bus.r0_req && bus.r1_req) begin
                    w_gnt0 = w_tie_r0;
                    w_gnt1 = !w_tie_r0;
                end else begin
                    w_gnt0 = bus.r0_req;
                    w_gnt1 = bus.r1_req;
                end
            end
            LOCK0:   w_gnt0 = bus.r0_req;
            LOCK1:   w_gnt1 = bus.r1_req;
            default: ;
        endcase

        if (!reset) begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
        end

        w_any_gnt  = w_gnt0 || w_gnt1;
        w_win_lock = w_gnt1 ? bus.r1_lock  : bus.r0_lock;
        w_win_we   = w_gnt1 ? bus.r1_we    : bus.r0_we;
        w_win_addr = w_gnt1 ? bus.r1_addr  : bus.r0_addr;
        w_win_data = w_gnt1 ? bus.r1_wdata : bus.r0_wdata;

        if (w_any_gnt) begin
            w_last_nxt = w_gnt1;
            if (w_win_lock && !w_timeout) begin
                w_state_nxt = w_gnt1 ? LOCK1 : LOCK0;
            end else begin
                w_state_nxt = IDLE;
            end
        end else if (w_timeout) begin
            w_state_nxt = IDLE;
            w_last_nxt  = (r_state == LOCK1);
        end

        // Counter restarts on entry into a lock state and runs while it persists
        if ((w_state_nxt != IDLE) && (w_state_nxt == r_state)) begin
            w_cnt_nxt = CNT_W'(r_cnt + 1'b1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_last      <= 1'b1;
            r_cnt       <= '0;
            r_bram_addr <= '0;
            r_bram_data <= '0;
            r_bram_we   <= 1'b0;
            r_v1        <= 1'b0;
            r_id1       <= 1'b0;
            r_v2        <= 1'b0;
            r_id2       <= 1'b0;
            r_rdata0    <= '0;
            r_rdata1    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_last    <= w_last_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bram_we <= w_any_gnt && w_win_we;
            if (w_any_gnt) begin
                r_bram_addr <= w_win_addr;
                r_bram_data <= w_win_data;
            end
            r_v1  <= w_any_gnt && !w_win_we;
            r_id1 <= w_gnt1;
            r_v2  <= r_v1;
            r_id2 <= r_id1;
            if (r_v2 && !r_id2) r_rdata0 <= bus.bram_q;
            if (r_v2 &&  r_id2) r_rdata1 <= bus.bram_q;
        end
    end

    assign bus.r0_gnt    = w_gnt0;
    assign bus.r1_gnt    = w_gnt1;
    assign bus.bram_addr = r_bram_addr;
    assign bus.bram_data = r_bram_data;
    assign bus.bram_we   = r_bram_we;
    assign bus.locked    = (r_state != IDLE);

    // bram_q is the BRAM's own output register; the hold registers keep it between strobes
    assign bus.r0_rvalid = r_v2 && !r_id2;
    assign bus.r1_rvalid = r_v2 &&  r_id2;
    assign bus.r0_rdata  = bus.r0_rvalid ? bus.bram_q : r_rdata0;
    assign bus.r1_rdata  = bus.r1_rvalid ? bus.bram_q : r_rdata1;
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter: BRAM model, shadow memory and read scoreboard.
module tb_bram_port_arbiter;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned ADDR_W   = 10;
    localparam int unsigned LOCK_MAX = 8;

    typedef struct {
        int          id;
        logic [15:0] data;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc     = 0;
    int   n_check = 0;
    int   n_pass  = 0;
    exp_t sb[$];

    bit [DATA_W-1:0] mem    [1024];
    bit [DATA_W-1:0] shadow [1024];

    bram_port_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    bram_port_arbiter #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .LOCK_MAX(LOCK_MAX)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Single-port BRAM with registered output (read-before-write)
    always @(posedge clk) begin
        if (bus.bram_we) mem[bus.bram_addr] <= bus.bram_data;
        bus.bram_q <= mem[bus.bram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_check++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Read-return monitor: every strobe must match the oldest expected read
    always @(negedge clk) begin
        if (bus.r0_rvalid === 1'b1 || bus.r1_rvalid === 1'b1) begin
            exp_t e;
            check("rvalid_onehot", 32'(bus.r0_rvalid && bus.r1_rvalid), 0);
            check("rvalid_expected", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("rvalid_id", 32'(bus.r1_rvalid), 32'(e.id));
                check("rvalid_cycle", 32'(cyc), 32'(e.due));
                check("rdata", 32'(bus.r1_rvalid ? bus.r1_rdata : bus.r0_rdata), 32'(e.data));
            end
        end
    end

    task automatic set0(input bit req, input bit we, input bit lock,
                        input logic [9:0] addr, input logic [15:0] wdata);
        bus.r0_req = req; bus.r0_we = we; bus.r0_lock = lock;
        bus.r0_addr = addr; bus.r0_wdata = wdata;
    endtask

    task automatic set1(input bit req, input bit we, input bit lock,
                        input logic [9:0] addr, input logic [15:0] wdata);
        bus.r1_req = req; bus.r1_we = we; bus.r1_lock = lock;
        bus.r1_addr = addr; bus.r1_wdata = wdata;
    endtask

    task automatic record(input int id, input bit we, input logic [9:0] addr,
                          input logic [15:0] wdata);
        if (we) shadow[addr] = wdata;
        else    sb.push_back('{id: id, data: shadow[addr], due: cyc + 2});
    endtask

    // One clock: check grants mid-cycle, log expected accesses, return #1 after the edge
    task automatic step(input bit e0, input bit e1, input bit track, input string tag);
        @(negedge clk);
        check({tag, "_gnt0"}, 32'(bus.r0_gnt), 32'(e0));
        check({tag, "_gnt1"}, 32'(bus.r1_gnt), 32'(e1));
        if (track && e0) record(0, bus.r0_we, bus.r0_addr, bus.r0_wdata);
        if (track && e1) record(1, bus.r1_we, bus.r1_addr, bus.r1_wdata);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit fixed;
`ifdef ARB_FIXED_PRIORITY_EN
        fixed = 1'b1;
`else
        fixed = 1'b0;
`endif
        reset = 1'b0;
        set0(1, 0, 0, 10'h005, 16'h0);
        set1(0, 0, 0, 10'h000, 16'h0);

        // Reset with a pending request
        step(0, 0, 1, "rst_a");
        step(0, 0, 1, "rst_b");
        check("rst_bram_we",   32'(bus.bram_we), 0);
        check("rst_bram_addr", 32'(bus.bram_addr), 0);
        check("rst_bram_data", 32'(bus.bram_data), 0);
        check("rst_rvalid",    32'({bus.r0_rvalid, bus.r1_rvalid}), 0);
        check("rst_rdata",     32'({bus.r0_rdata, bus.r1_rdata}), 0);
        check("rst_locked",    32'(bus.locked), 0);
        reset = 1'b1;

        // First read after reset
        step(1, 0, 1, "rd5");
        set0(0, 0, 0, 10'h0, 16'h0);
        check("rd5_addr", 32'(bus.bram_addr), 32'h005);
        check("rd5_we",   32'(bus.bram_we), 0);

        // Write then read back
        set0(1, 1, 0, 10'h00A, 16'hBEEF);
        step(1, 0, 1, "wrA");
        check("wrA_we",   32'(bus.bram_we), 1);
        check("wrA_addr", 32'(bus.bram_addr), 32'h00A);
        check("wrA_data", 32'(bus.bram_data), 32'hBEEF);
        set0(1, 0, 0, 10'h00A, 16'h0);
        step(1, 0, 1, "rdA");
        set0(0, 0, 0, 10'h0, 16'h0);
        check("rdA_we", 32'(bus.bram_we), 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, "drainA");
        check("rdA_hold",   32'(bus.r0_rdata), 32'hBEEF);
        check("rdA_idle_v", 32'(bus.r0_rvalid), 0);

        // Seed data; the r1 write leaves r1 as last grant
        set0(1, 1, 0, 10'h001, 16'h1111);
        step(1, 0, 1, "wr1");
        set0(0, 0, 0, 10'h0, 16'h0);
        set1(1, 1, 0, 10'h002, 16'h2222);
        step(0, 1, 1, "wr2");

        // Continuous contention
        set0(1, 0, 0, 10'h001, 16'h0);
        set1(1, 0, 0, 10'h002, 16'h0);
        for (int i = 0; i < 6; i++) begin
            if (fixed) step(1, 0, 1, "both");
            else       step(i % 2 == 0, i % 2 == 1, 1, "both");
        end
        set0(0, 0, 0, 10'h0, 16'h0);
        set1(0, 0, 0, 10'h0, 16'h0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, "drainB");

        // r1 atomic read-modify-write while r0 waits
        set1(1, 0, 1, 10'h010, 16'h0);
        step(0, 1, 1, "lk1_rd");
        check("lk1_locked_a", 32'(bus.locked), 1);
        set0(1, 0, 0, 10'h003, 16'h0);
        set1(0, 0, 0, 10'h0, 16'h0);
        step(0, 0, 1, "lk1_wait");
        check("lk1_locked_b", 32'(bus.locked), 1);
        set1(1, 1, 0, 10'h010, 16'h1234);
        step(0, 1, 1, "lk1_wr");
        check("lk1_unlocked", 32'(bus.locked), 0);
        set1(0, 0, 0, 10'h0, 16'h0);
        step(1, 0, 1, "r0_after");
        set0(1, 0, 0, 10'h010, 16'h0);
        step(1, 0, 1, "rd10");
        set0(0, 0, 0, 10'h0, 16'h0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, "drainC");

        // Abandoned r0 lock is released after LOCK_MAX cycles
        set0(1, 0, 1, 10'h004, 16'h0);
        step(1, 0, 1, "lk0");
        set0(0, 0, 0, 10'h0, 16'h0);
        set1(1, 0, 0, 10'h006, 16'h0);
        for (int i = 0; i < int'(LOCK_MAX); i++) begin
            check("lk0_locked", 32'(bus.locked), 1);
            step(0, 0, 1, "lk0_hold");
        end
        check("lk0_released", 32'(bus.locked), 0);
        step(0, 1, 1, "lk0_r1");
        set1(0, 0, 0, 10'h0, 16'h0);

        // Lock renewed every cycle: timeout still forces IDLE, lock bit ignored
        set0(1, 0, 1, 10'h007, 16'h0);
        set1(1, 0, 0, 10'h008, 16'h0);
        for (int i = 0; i < int'(LOCK_MAX) + 1; i++) step(1, 0, 1, "lkto");
        step(fixed, !fixed, 1, "lkto_next");
        set0(0, 0, 0, 10'h0, 16'h0);
        set1(0, 0, 0, 10'h0, 16'h0);
        check("lkto_locked", 32'(bus.locked), 32'(fixed));
        for (int i = 0; i < 3; i++) step(0, 0, 1, "drainD");

        // Reset right after a read grant discards that read
        set0(1, 0, 0, 10'h00A, 16'h0);
        step(1, 0, 0, "rd_rst");
        set0(0, 0, 0, 10'h0, 16'h0);
        reset = 1'b0;
        step(0, 0, 0, "rst_mid");
        reset = 1'b1;
        check("rst_mid_locked", 32'(bus.locked), 0);
        for (int i = 0; i < 4; i++) begin
            check("rst_mid_rvalid", 32'({bus.r0_rvalid, bus.r1_rvalid}), 0);
            step(0, 0, 0, "rst_quiet");
        end

        check("sb_empty", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end
endmodule
